fn_sw_arb: RTL

//  - Shares one W-bit two-operand logic-function unit (AND/OR/XOR/XNOR, selected by 2-bit op) among NREQ requesters.
//  - Round-robin arbitration; valid/ready handshake on request and response sides; registered result tagged with requester id.
//  - Sits between multiple client blocks and a single fn_sw_core instance; one operation in flight at a time.

---
 rtl/fn_sw_pkg.sv | 16 +
 rtl/fn_sw_core.sv | 25 ++
 rtl/fn_sw_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fn_sw_pkg.sv
// Shared definitions for the switched logic-function unit and its arbiter.
// Contents: logic op codes and the arbiter FSM state type.
package fn_sw_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/fn_sw_core.sv
// Purely combinational W-bit two-operand logic unit.
// Ports: a, b - operands; sel - op code (AND/OR/XOR/XNOR); y - result.
module fn_sw_core
   import fn_sw_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   sel,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/fn_sw_arb.sv
// Round-robin front end sharing one fn_sw_core among NREQ requesters.
// One operation in flight; result registered and tagged with requester id.
// Ports: clk, rst_n (async, active low); req_valid/req_ready per requester;
//        req_a/req_b (W bits each, requester i at [i*W +: W]);
//        req_sel (2 bits each); rsp_valid/rsp_ready/rsp_y/rsp_id response side;
//        done_cnt - saturating completed-transaction count.
// Build option: define FN_SW_ARB_CNT_EN to add the done_cnt port and counter.
module fn_sw_arb
   import fn_sw_pkg::*;
#(
   parameter  int unsigned W    = 8,
   parameter  int unsigned NREQ = 2,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*2-1:0] req_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_y,
   output logic [IDW-1:0]    rsp_id
`ifdef FN_SW_ARB_CNT_EN
   ,
   output logic [15:0]       done_cnt
`endif
);

   state_t         state_q, state_d;
   logic [IDW-1:0] last_gnt_q;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic [W-1:0]   gnt_a, gnt_b;
   logic [1:0]     gnt_sel;
   logic           accept, load_rsp, fire;
   logic [W-1:0]   a_q, b_q;
   logic [1:0]     sel_q;
   logic [IDW-1:0] id_q;
   logic [W-1:0]   y_c;

   // Round-robin search starting just after the last winner; also muxes its operands.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_a   = '0;
      gnt_b   = '0;
      gnt_sel = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         int unsigned idx;
         idx = (32'(last_gnt_q) + k) % NREQ;
         if (!gnt_any && req_valid[IDW'(idx)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(idx);
            gnt_a   = W'(req_a >> (idx * W));
            gnt_b   = W'(req_b >> (idx * W));
            gnt_sel = 2'(req_sel >> (idx * 2));
         end
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      load_rsp  = 1'b0;
      fire      = 1'b0;
      case (state_q)
         IDLE: begin
            // Gate on rst_n so no grant is advertised while reset is held.
            if (gnt_any && rst_n) begin
               req_ready[gnt_idx] = 1'b1;
               accept             = req_valid[gnt_idx];
               state_d            = EXEC;
            end
         end
         EXEC: begin
            load_rsp = 1'b1;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               fire    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   fn_sw_core #(.W(W)) u_core (
      .a   (a_q),
      .b   (b_q),
      .sel (sel_q),
      .y   (y_c)
   );

   // Capture registers, pointer and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= IDW'(NREQ - 1);
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
         id_q       <= '0;
         rsp_valid  <= 1'b0;
         rsp_y      <= '0;
         rsp_id     <= '0;
      end else begin
         if (accept) begin
            a_q        <= gnt_a;
            b_q        <= gnt_b;
            sel_q      <= gnt_sel;
            id_q       <= gnt_idx;
            last_gnt_q <= gnt_idx;
         end
         if (load_rsp) begin
            rsp_y     <= y_c;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
         end else if (fire) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef FN_SW_ARB_CNT_EN
   logic [15:0] cnt_q;

   // Completed-transaction counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         cnt_q <= '0;
      else if (fire && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
   end

   assign done_cnt = cnt_q;
`endif

endmodule
